// File: rtl/div_hilo_ctrl.sv
// Sequencer in front of the combinational divider: holds operands for a
// settle window, then captures quotient/remainder into LO/HI.
module div_hilo_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend_in,
  input  logic [31:0] divisor_in,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept, zdiv, capture;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && divisor_in != '0) state_nxt = WAIT;
      WAIT: if (cnt == '0)                 state_nxt = IDLE;
    endcase
  end

  // A zero divisor completes in IDLE without ever entering the settle window.
  always_comb begin
    accept  = (state == IDLE) && start;
    zdiv    = accept && (divisor_in == '0);
    capture = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      done <= zdiv | capture;
      if (accept) begin
        div_dividend <= dividend_in;
        div_divisor  <= divisor_in;
        div_by_zero  <= zdiv;
      end
      if (state == WAIT) begin
        if (capture) begin
          lo   <= div_quotient;
          hi   <= div_remainder;
          busy <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end else begin
        if (hi_wr) hi <= wr_data;
        if (lo_wr) lo <= wr_data;
        if (accept && !zdiv) begin
          cnt  <= CNT_INIT;
          busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: directed vector table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_div_hilo_ctrl;
  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1, start = 1'b0, hi_wr = 1'b0, lo_wr = 1'b0;
  logic [31:0] dividend_in = '0, divisor_in = '0, wr_data = '0;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder, hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0, errors = 0;

  div_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // External combinational divider
  assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

  // Reference model: operation due a fixed number of edges after acceptance
  logic [31:0] m_hi = '0, m_lo = '0, m_dd = '0, m_ds = '0, m_q = '0, m_r = '0;
  bit          m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int          m_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_hi = '0; m_lo = '0; m_dd = '0; m_ds = '0;
      m_busy = 0; m_done = 0; m_dbz = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_lo = m_q; m_hi = m_r; m_done = 1; m_busy = 0;
        end
      end else begin
        if (hi_wr) m_hi = wr_data;
        if (lo_wr) m_lo = wr_data;
        if (start) begin
          m_dd = dividend_in; m_ds = divisor_in;
          m_dbz = (divisor_in == 0);
          if (divisor_in == 0) m_done = 1;
          else begin
            m_busy = 1; m_left = S;
            m_q = dividend_in / divisor_in;
            m_r = dividend_in % divisor_in;
          end
        end
      end
    end
  endtask

  task automatic model_cmp();
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_dbz", 32'(div_by_zero), 32'(m_dbz));
    chk("model_div_dividend", div_dividend, m_dd);
    chk("model_div_divisor", div_divisor, m_ds);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    model_cmp();
  endtask

  task automatic drive(input bit r, input bit st, input logic [31:0] dd, input logic [31:0] ds,
                       input bit hw, input bit lw, input logic [31:0] wd);
    reset = r; start = st; dividend_in = dd; divisor_in = ds;
    hi_wr = hw; lo_wr = lw; wr_data = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst, st; logic [31:0] dd, ds; bit hw, lw; logic [31:0] wd;
    bit e_busy, e_done, e_dbz; logic [31:0] e_hi, e_lo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit st, logic [31:0] dd, logic [31:0] ds, bit hw, bit lw,
                              logic [31:0] wd, bit eb, bit ed, bit ez, logic [31:0] ehi, logic [31:0] elo);
    vec_t v;
    v.rst = r; v.st = st; v.dd = dd; v.ds = ds; v.hw = hw; v.lw = lw; v.wd = wd;
    v.e_busy = eb; v.e_done = ed; v.e_dbz = ez; v.e_hi = ehi; v.e_lo = elo;
    return v;
  endfunction

  initial begin
    // reset 2, idle 5
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    // basic 100/7
    tbl.push_back(mk(0,1,100,7,0,0,0, 1,0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,0,2,14));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,2,14));
    // prime HI/LO, then divide by zero, then 9/3 clears the flag
    tbl.push_back(mk(0,0,0,0,1,0,32'hAAAA, 0,0,0,32'hAAAA,14));
    tbl.push_back(mk(0,0,0,0,0,1,32'h5555, 0,0,0,32'hAAAA,32'h5555));
    tbl.push_back(mk(0,1,55,0,0,0,0, 0,1,1,32'hAAAA,32'h5555));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,32'hAAAA,32'h5555));
    tbl.push_back(mk(0,1,9,3,0,0,0, 1,0,0,32'hAAAA,32'h5555));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,32'hAAAA,32'h5555));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,3));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].dd, tbl[i].ds, tbl[i].hw, tbl[i].lw, tbl[i].wd);
      cycle();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(tbl[i].e_dbz));
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].e_hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].e_lo);
    end

    // start while busy is ignored (also back-to-back out of the done cycle)
    drive(0, 1, 1000, 10, 0, 0, 0); cycle();
    idle(); cycle();
    drive(0, 1, 8, 2, 0, 0, 0); cycle();
    chk("busy_start_dd", div_dividend, 1000);
    chk("busy_start_ds", div_divisor, 10);
    idle(); cycle();
    chk("busy_start_no_early_done", 32'(done), 0);
    cycle();
    chk("busy_start_done", 32'(done), 1);
    chk("busy_start_lo", lo, 100);
    chk("busy_start_hi", hi, 0);
    cycle();
    chk("busy_start_no_second_done", 32'(done), 0);

    // reset mid-operation
    drive(0, 1, 50, 5, 0, 0, 0); cycle();
    idle(); cycle();
    drive(1, 0, 0, 0, 0, 0, 0); cycle();
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst_mid_no_done", 32'(done), 0);
    end
    drive(0, 1, 50, 5, 0, 0, 0); cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    chk("rst_redo_done", 32'(done), 1);
    chk("rst_redo_lo", lo, 10);
    chk("rst_redo_hi", hi, 0);

    // HI write during busy ignored; start in done cycle accepted
    drive(0, 1, 40, 6, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0, 32'h1234); cycle();
    chk("busy_hiwr_ignored", hi, 0);
    idle(); cycle(); cycle(); cycle();
    chk("b2b_first_done", 32'(done), 1);
    chk("b2b_first_hi", hi, 4);
    chk("b2b_first_lo", lo, 6);
    drive(0, 1, 17, 5, 0, 0, 0); cycle();
    chk("b2b_accept_busy", 32'(busy), 1);
    idle();
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    chk("b2b_second_done", 32'(done), 1);
    chk("b2b_second_lo", lo, 3);
    chk("b2b_second_hi", hi, 2);
    drive(0, 0, 0, 0, 1, 1, 32'hDEAD); cycle();
    chk("idle_wr_hi", hi, 32'hDEAD);
    chk("idle_wr_lo", lo, 32'hDEAD);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ds;
      ds = ($urandom_range(0, 4) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), $urandom, ds,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < S + 2; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
